// File: rtl/majority_pkg.sv
// Shared constants, FSM encoding and latched-request payload for the majority vote scheduler.
package majority_pkg;

  localparam int unsigned NUM_REQ    = 4;
  localparam int unsigned VOTE_W     = 7;
  localparam int unsigned MAJ_THRESH = 4;
  localparam int unsigned ID_W       = 2;
  localparam int unsigned ONES_W     = 3;
  localparam int unsigned CNT_W      = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    HOLD = 2'd2
  } state_t;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [VOTE_W-1:0] vote;
  } txn_t;

endpackage

// File: rtl/rr_arbiter4.sv
// Four-way round-robin grant: first asserted request at or above ptr, wrapping mod 4.
module rr_arbiter4
  import majority_pkg::*;
(
  input  logic [3:0]      req,
  input  logic [ID_W-1:0] ptr,
  output logic [3:0]      gnt,
  output logic [ID_W-1:0] gnt_id,
  output logic            any
);

  logic            found;
  logic [ID_W-1:0] idx;

  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    found  = 1'b0;
    idx    = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      idx = ptr + ID_W'(i);
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        gnt_id   = idx;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/majority_vote_sched.sv
// Accepts one vote vector at a time from four requesters, reports its majority and popcount.
module majority_vote_sched #(
  parameter int unsigned NUM_REQ = majority_pkg::NUM_REQ,
  parameter int unsigned VOTE_W  = majority_pkg::VOTE_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*VOTE_W-1:0] req_vote,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic                      res_out,
  output logic [1:0]                res_id,
  output logic [2:0]                res_ones,
  output logic [7:0]                eval_cnt,
  output logic                      busy
);
  import majority_pkg::*;

  state_t            state_q, state_d;
  logic [ID_W-1:0]   ptr_q;
  txn_t              txn_q;
  logic              res_out_q;
  logic [ID_W-1:0]   res_id_q;
  logic [ONES_W-1:0] res_ones_q;
  logic [CNT_W-1:0]  cnt_q;

  logic [3:0]        gnt;
  logic [ID_W-1:0]   gnt_id;
  logic              any;
  logic              accept;
  logic              deliver;
  logic [ONES_W-1:0] ones;

  rr_arbiter4 u_arb (
    .req    (req_valid),
    .ptr    (ptr_q),
    .gnt    (gnt),
    .gnt_id (gnt_id),
    .any    (any)
  );

  // Next-state and handshake strobes; req_ready is gated by rst_n so nothing is accepted in reset.
  always_comb begin
    state_d   = state_q;
    req_ready = '0;
    accept    = 1'b0;
    deliver   = 1'b0;
    case (state_q)
      IDLE: begin
        if (any && rst_n) begin
          req_ready = gnt;
          accept    = 1'b1;
          state_d   = EVAL;
        end
      end
      EVAL: state_d = HOLD;
      HOLD: begin
        if (res_ready) begin
          deliver = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ones = '0;
    for (int unsigned i = 0; i < VOTE_W; i++) begin
      ones = ones + ONES_W'(txn_q.vote[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      txn_q      <= '0;
      res_out_q  <= 1'b0;
      res_id_q   <= '0;
      res_ones_q <= '0;
      cnt_q      <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        ptr_q      <= gnt_id + ID_W'(1);
        txn_q.id   <= gnt_id;
        txn_q.vote <= req_vote[VOTE_W*32'(gnt_id) +: VOTE_W];
      end
      // Result registers change only on the EVAL->HOLD edge so they stay put while res_valid is high.
      if (state_q == EVAL) begin
        res_out_q  <= (ones >= ONES_W'(MAJ_THRESH));
        res_ones_q <= ones;
        res_id_q   <= txn_q.id;
      end
      if (deliver) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign res_valid = (state_q == HOLD);
  assign busy      = (state_q != IDLE);
  assign res_out   = res_out_q;
  assign res_id    = res_id_q;
  assign res_ones  = res_ones_q;
  assign eval_cnt  = cnt_q;

endmodule

// File: tb/tb_majority_vote_sched.sv
// Directed and randomized checks of majority_vote_sched against a transaction-level reference model.
module tb_majority_vote_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [27:0] req_vote;
  logic [3:0]  req_ready;
  logic        res_valid;
  logic        res_ready;
  logic        res_out;
  logic [1:0]  res_id;
  logic [2:0]  res_ones;
  logic [7:0]  eval_cnt;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state: next search pointer and delivered-result count.
  int          m_ptr = 0;
  logic [7:0]  m_cnt = 8'd0;

  majority_vote_sched dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_vote  (req_vote),
    .req_ready (req_ready),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_out   (res_out),
    .res_id    (res_id),
    .res_ones  (res_ones),
    .eval_cnt  (eval_cnt),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int model_grant(input logic [3:0] m, input int p);
    for (int k = 0; k < 4; k++) begin
      if (m[(p + k) % 4]) return (p + k) % 4;
    end
    return -1;
  endfunction

  function automatic logic [6:0] vote_of(input logic [27:0] vv, input int ch);
    logic [27:0] t;
    t = vv >> (7 * ch);
    return t[6:0];
  endfunction

  // One full transaction from IDLE: grant, EVAL, HOLD (optionally stalled), delivery.
  task automatic txn(input string tag, input logic [3:0] mask, input logic [27:0] votes,
                     input int stall);
    int         g;
    logic [6:0] v;
    int         pc;
    req_valid = mask;
    req_vote  = votes;
    res_ready = (stall == 0);
    #1;
    g  = model_grant(mask, m_ptr);
    v  = vote_of(votes, g);
    pc = $countones(v);
    check({tag, ".grant"}, 32'(req_ready), 32'(4'b0001 << g));
    check({tag, ".idle_busy"}, 32'(busy), 32'd0);
    step();
    m_ptr = (g + 1) % 4;
    check({tag, ".eval_busy"}, 32'(busy), 32'd1);
    check({tag, ".eval_ready"}, 32'(req_ready), 32'd0);
    check({tag, ".eval_valid"}, 32'(res_valid), 32'd0);
    step();
    check({tag, ".hold_valid"}, 32'(res_valid), 32'd1);
    check({tag, ".res_out"}, 32'(res_out), 32'(pc >= 4));
    check({tag, ".res_ones"}, 32'(res_ones), 32'(pc));
    check({tag, ".res_id"}, 32'(res_id), 32'(g));
    for (int s = 0; s < stall; s++) begin
      step();
      check({tag, ".stall_valid"}, 32'(res_valid), 32'd1);
      check({tag, ".stall_out"}, 32'(res_out), 32'(pc >= 4));
      check({tag, ".stall_ones"}, 32'(res_ones), 32'(pc));
      check({tag, ".stall_id"}, 32'(res_id), 32'(g));
      check({tag, ".stall_ready"}, 32'(req_ready), 32'd0);
      check({tag, ".stall_cnt"}, 32'(eval_cnt), 32'(m_cnt));
    end
    res_ready = 1'b1;
    step();
    m_cnt = m_cnt + 8'd1;
    check({tag, ".cnt"}, 32'(eval_cnt), 32'(m_cnt));
    check({tag, ".done_valid"}, 32'(res_valid), 32'd0);
    check({tag, ".done_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    logic [3:0]  mask;
    logic [27:0] votes;
    rst_n     = 1'b0;
    req_valid = 4'hF;
    req_vote  = '0;
    res_ready = 1'b0;
    #12;
    check("rst.ready", 32'(req_ready), 32'd0);
    check("rst.valid", 32'(res_valid), 32'd0);
    check("rst.out", 32'(res_out), 32'd0);
    check("rst.id", 32'(res_id), 32'd0);
    check("rst.ones", 32'(res_ones), 32'd0);
    check("rst.cnt", 32'(eval_cnt), 32'd0);
    check("rst.busy", 32'(busy), 32'd0);

    // Reset during HOLD: ch1 accepted, then reset wipes the result before delivery.
    @(posedge clk); #1;
    rst_n     = 1'b1;
    req_valid = 4'b0010;
    req_vote  = {7'd0, 7'd0, 7'b1111000, 7'd0};
    #1;
    check("rsthold.grant", 32'(req_ready), 32'b0010);
    step();
    req_valid = 4'b0000;
    step();
    check("rsthold.valid", 32'(res_valid), 32'd1);
    req_valid = 4'hF;
    rst_n     = 1'b0;
    #1;
    check("rsthold.valid_gone", 32'(res_valid), 32'd0);
    check("rsthold.busy", 32'(busy), 32'd0);
    check("rsthold.cnt", 32'(eval_cnt), 32'd0);
    check("rsthold.ready_in_rst", 32'(req_ready), 32'd0);
    step();
    check("rsthold.cnt_after", 32'(eval_cnt), 32'd0);
    rst_n = 1'b1;
    m_ptr = 0;
    m_cnt = 8'd0;

    // Contention: all valid, expect order 0,1,2,3,0 back to back.
    votes = {7'b1110000, 7'b0000111, 7'b1010101, 7'b0110011};
    for (int i = 0; i < 5; i++) begin
      check("cont.order_ptr", 32'(model_grant(4'hF, m_ptr)), 32'(i % 4));
      txn("cont", 4'hF, votes, 0);
    end

    txn("single", 4'b0001, {21'd0, 7'b1001101}, 0);
    txn("below", 4'b0100, {7'd0, 7'b1000001, 14'd0}, 0);
    txn("bp", 4'b1000, {7'b0110110, 21'd0}, 10);

    // No requests: FSM stays idle and the pointer stays put.
    req_valid = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      step();
      check("idle.busy", 32'(busy), 32'd0);
      check("idle.ready", 32'(req_ready), 32'd0);
      check("idle.cnt", 32'(eval_cnt), 32'(m_cnt));
    end

    for (int i = 0; i < 60; i++) begin
      mask  = 4'($urandom_range(1, 15));
      votes = 28'($urandom);
      txn("rand", mask, votes, int'($urandom_range(0, 2)));
    end

    // Drive the counter around to zero with all-ones votes.
    for (int i = 0; i < 300 && (i == 0 || m_cnt != 8'd0); i++) begin
      mask = 4'($urandom_range(1, 15));
      txn("wrap", mask, 28'hFFFFFFF, 0);
    end
    check("wrap.zero", 32'(eval_cnt), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
